// File: rtl/reg_write_ctrl.sv
// Write-side front end for the register bank: synchronises and debounces the write
// button and issues one RegWrite pulse per press. Optional macro FILL_PATTERN_EN adds a power-up fill (reg i <= i).
module reg_write_ctrl #(
  parameter int BIT_ADDR   = 3,
  parameter int BIT_DATO   = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] sw_addr,
  input  logic [BIT_DATO-1:0] sw_dat,
  input  logic                btn_wr,
  output logic [BIT_ADDR-1:0] addrW,
  output logic [BIT_DATO-1:0] datW,
  output logic                RegWrite,
  output logic                busy,
  output logic [7:0]          wr_count
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_REL
`ifdef FILL_PATTERN_EN
    , FILL
`endif
  } state_t;

  state_t r_state, w_state_nx;

  logic                r_btn_s1, r_btn_s2;
  logic [BIT_ADDR-1:0] r_addr_s1, r_addr_s2;
  logic [BIT_DATO-1:0] r_dat_s1, r_dat_s2;
  logic [CW-1:0]       r_deb_cnt;
  logic                r_btn_db, r_btn_db_d;
  logic [BIT_ADDR-1:0] r_addrW;
  logic [BIT_DATO-1:0] r_datW;
  logic [7:0]          r_wr_count;
  logic                w_rise, w_latch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_addr_s1 <= '0;
      r_addr_s2 <= '0;
      r_dat_s1  <= '0;
      r_dat_s2  <= '0;
    end else begin
      r_btn_s1  <= btn_wr;
      r_btn_s2  <= r_btn_s1;
      r_addr_s1 <= sw_addr;
      r_addr_s2 <= r_addr_s1;
      r_dat_s1  <= sw_dat;
      r_dat_s2  <= r_dat_s1;
    end
  end

  // Debounced level resets to "pressed" so a button held through reset never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt  <= '0;
      r_btn_db   <= 1'b1;
      r_btn_db_d <= 1'b1;
    end else begin
      r_btn_db_d <= r_btn_db;
      if (r_btn_s2 == r_btn_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_MAX) begin
        r_btn_db  <= ~r_btn_db;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_rise = r_btn_db & ~r_btn_db_d;

`ifdef FILL_PATTERN_EN
  logic                r_fill_act;
  logic [BIT_ADDR-1:0] r_fill_idx;

  // Fill writes begin on the first edge after reset release; r_fill_act gates them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_act <= 1'b0;
      r_fill_idx <= '0;
    end else begin
      r_fill_act <= 1'b1;
      if (r_state == FILL && r_fill_act)
        r_fill_idx <= r_fill_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef FILL_PATTERN_EN
      r_state <= FILL;
`else
      r_state <= IDLE;
`endif
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_latch    = 1'b1;
          w_state_nx = WRITE;
        end
      end
      WRITE:    w_state_nx = WAIT_REL;
      WAIT_REL: if (!r_btn_db) w_state_nx = IDLE;
`ifdef FILL_PATTERN_EN
      FILL:     if (r_fill_act && r_fill_idx == '1) w_state_nx = IDLE;
`endif
      default:  w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addrW    <= '0;
      r_datW     <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_latch) begin
        r_addrW <= r_addr_s2;
        r_datW  <= r_dat_s2;
      end
      if (r_state == WRITE)
        r_wr_count <= r_wr_count + 8'd1;
    end
  end

  // Strobe is decoded from state so reset drops it without waiting for a clock.
  always_comb begin
    addrW    = r_addrW;
    datW     = r_datW;
    RegWrite = (r_state == WRITE);
    busy     = (r_state != IDLE);
`ifdef FILL_PATTERN_EN
    if (r_state == FILL) begin
      addrW    = r_fill_idx;
      datW     = BIT_DATO'(r_fill_idx);
      RegWrite = r_fill_act;
      busy     = r_fill_act;
    end
`endif
  end

  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed bench for reg_write_ctrl with DEB_CYCLES=4; fill checks run when FILL_PATTERN_EN is defined.
module tb_reg_write_ctrl;
  localparam int BA = 3;
  localparam int BD = 4;
`ifdef FILL_PATTERN_EN
  localparam int FILL_N = 8;
`else
  localparam int FILL_N = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BA-1:0] sw_addr = '0;
  logic [BD-1:0] sw_dat = '0;
  logic          btn_wr = 1'b0;
  logic [BA-1:0] addrW;
  logic [BD-1:0] datW;
  logic          RegWrite, busy;
  logic [7:0]    wr_count;

  int nvec = 0, nerr = 0, cyc = 0, npulse = 0, nwide = 0, pulse_cyc = 0;
  logic [BA-1:0] cap_addr = '0;
  logic [BD-1:0] cap_dat = '0;
  logic          prev_rw = 1'b0;

  reg_write_ctrl #(.BIT_ADDR(BA), .BIT_DATO(BD), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw_addr(sw_addr), .sw_dat(sw_dat), .btn_wr(btn_wr),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (RegWrite) begin
      npulse++;
      if (prev_rw) nwide++;
      pulse_cyc = cyc;
      cap_addr  = addrW;
      cap_dat   = datW;
    end
    prev_rw = RegWrite;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    btn_wr = 1'b0;
    step(3);
    rst = 1'b1;
    step(25);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    btn_wr = 1'b0;
    @(negedge clk);
    nvec++; if (addrW !== 3'd0) begin nerr++; $display("FAIL reset_addrW got %0d want 0", addrW); end
    nvec++; if (datW !== 4'd0) begin nerr++; $display("FAIL reset_datW got %0d want 0", datW); end
    nvec++; if (RegWrite !== 1'b0) begin nerr++; $display("FAIL reset_RegWrite got %b want 0", RegWrite); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (wr_count !== 8'd0) begin nerr++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
    do_reset();
  endtask

  task automatic test_clean_press;
    int n0, w0, t0, lat;
    n0 = npulse; w0 = nwide;
    sw_addr = 3'd5; sw_dat = 4'hA;
    step(3);
    btn_wr = 1'b1; t0 = cyc;
    step(20);
    lat = pulse_cyc - t0;
    nvec++; if (npulse - n0 !== 1) begin nerr++; $display("FAIL clean_pulses got %0d want 1", npulse - n0); end
    nvec++; if (nwide !== w0) begin nerr++; $display("FAIL clean_width got %0d wide cycles want 0", nwide - w0); end
    nvec++; if (cap_addr !== 3'd5) begin nerr++; $display("FAIL clean_addr got %0d want 5", cap_addr); end
    nvec++; if (cap_dat !== 4'hA) begin nerr++; $display("FAIL clean_dat got %h want a", cap_dat); end
    nvec++; if (lat < 6 || lat > 8) begin nerr++; $display("FAIL clean_latency got %0d want 7+-1", lat); end
    nvec++; if (wr_count !== 8'd1) begin nerr++; $display("FAIL clean_wr_count got %0d want 1", wr_count); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL clean_busy_held got %b want 1", busy); end
    btn_wr = 1'b0;
    repeat (4) @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL clean_busy_release got %b want 1", busy); end
    repeat (6) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL clean_busy_idle got %b want 0", busy); end
    step(2);
  endtask

  task automatic test_bounce;
    int n0, s0, lat;
    n0 = npulse;
    sw_addr = 3'd3; sw_dat = 4'h6;
    step(3);
    for (int i = 0; i < 12; i++) begin
      btn_wr = ((i % 4) < 2);
      step(1);
    end
    btn_wr = 1'b1; s0 = cyc;
    nvec++; if (npulse - n0 !== 0) begin nerr++; $display("FAIL bounce_no_write got %0d pulses want 0", npulse - n0); end
    step(20);
    lat = pulse_cyc - s0;
    nvec++; if (npulse - n0 !== 1) begin nerr++; $display("FAIL bounce_pulses got %0d want 1", npulse - n0); end
    nvec++; if (lat < 6 || lat > 8) begin nerr++; $display("FAIL bounce_latency got %0d want 7+-1", lat); end
    nvec++; if (cap_addr !== 3'd3 || cap_dat !== 4'h6) begin nerr++; $display("FAIL bounce_data got %0d/%h want 3/6", cap_addr, cap_dat); end
    btn_wr = 1'b0;
    step(12);
  endtask

  task automatic test_switch_change;
    int n0;
    logic found;
    logic [7:0] wc;
    n0 = npulse; found = 1'b0;
    sw_addr = 3'd2; sw_dat = 4'h3;
    step(3);
    btn_wr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (RegWrite) begin found = 1'b1; break; end
    end
    step(1);
    sw_dat = 4'hC;
    nvec++; if (found !== 1'b1) begin nerr++; $display("FAIL swchg_timeout got no RegWrite within 20 cycles"); end
    nvec++; if (cap_dat !== 4'h3) begin nerr++; $display("FAIL swchg_pulse_dat got %h want 3", cap_dat); end
    step(3);
    nvec++; if (datW !== 4'h3) begin nerr++; $display("FAIL swchg_hold_dat got %h want 3", datW); end
    step(8);
    btn_wr = 1'b0;
    step(12);
    wc = wr_count;
    btn_wr = 1'b1;
    step(12);
    nvec++; if (cap_dat !== 4'hC) begin nerr++; $display("FAIL swchg_next_dat got %h want c", cap_dat); end
    nvec++; if (npulse - n0 !== 2) begin nerr++; $display("FAIL swchg_pulses got %0d want 2", npulse - n0); end
    nvec++; if (wr_count !== wc + 8'd1) begin nerr++; $display("FAIL swchg_wr_count got %0d want %0d", wr_count, wc + 8'd1); end
    btn_wr = 1'b0;
    step(12);
  endtask

  task automatic test_wrap;
    int n0;
    do_reset();
    n0 = npulse;
    sw_addr = 3'd1; sw_dat = 4'h7;
    step(3);
    for (int i = 0; i < 257; i++) begin
      btn_wr = 1'b1; step(10);
      btn_wr = 1'b0; step(10);
    end
    nvec++; if (npulse - n0 !== 257) begin nerr++; $display("FAIL wrap_pulses got %0d want 257", npulse - n0); end
    nvec++; if (wr_count !== 8'd1) begin nerr++; $display("FAIL wrap_wr_count got %0d want 1", wr_count); end
    nvec++; if (cap_addr !== 3'd1) begin nerr++; $display("FAIL wrap_addr got %0d want 1", cap_addr); end
  endtask

  task automatic test_reset_held;
    int n1, n2;
    logic found;
    found = 1'b0;
    sw_addr = 3'd4; sw_dat = 4'h9;
    step(3);
    btn_wr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (RegWrite) begin found = 1'b1; break; end
    end
    nvec++; if (found !== 1'b1) begin nerr++; $display("FAIL held_timeout got no RegWrite within 20 cycles"); end
    #1 rst = 1'b0;
    #1;
    nvec++; if (RegWrite !== 1'b0) begin nerr++; $display("FAIL held_RegWrite got %b want 0", RegWrite); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL held_busy got %b want 0", busy); end
    nvec++; if (addrW !== 3'd0 || datW !== 4'd0) begin nerr++; $display("FAIL held_addr_dat got %0d/%h want 0/0", addrW, datW); end
    nvec++; if (wr_count !== 8'd0) begin nerr++; $display("FAIL held_wr_count got %0d want 0", wr_count); end
    step(3);
    rst = 1'b1;
    n1 = npulse;
    step(30);
    nvec++; if (npulse - n1 !== FILL_N) begin nerr++; $display("FAIL held_no_write got %0d pulses want %0d", npulse - n1, FILL_N); end
    btn_wr = 1'b0;
    step(12);
    n2 = npulse;
    btn_wr = 1'b1;
    step(12);
    nvec++; if (npulse - n2 !== 1) begin nerr++; $display("FAIL held_repress got %0d pulses want 1", npulse - n2); end
    nvec++; if (cap_addr !== 3'd4 || cap_dat !== 4'h9) begin nerr++; $display("FAIL held_repress_data got %0d/%h want 4/9", cap_addr, cap_dat); end
    nvec++; if (wr_count !== 8'd1) begin nerr++; $display("FAIL held_wr_count_after got %0d want 1", wr_count); end
    btn_wr = 1'b0;
    step(12);
  endtask

`ifdef FILL_PATTERN_EN
  task automatic test_fill;
    int n0;
    logic [BD-1:0] d;
    rst = 1'b0;
    btn_wr = 1'b0;
    step(3);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) btn_wr = 1'b1;
      d = BD'(i);
      nvec++; if (RegWrite !== 1'b1) begin nerr++; $display("FAIL fill_rw_%0d got %b want 1", i, RegWrite); end
      nvec++; if (addrW !== BA'(i) || datW !== d) begin nerr++; $display("FAIL fill_pair_%0d got %0d/%0d want %0d/%0d", i, addrW, datW, i, d); end
      nvec++; if (busy !== 1'b1 || wr_count !== 8'd0) begin nerr++; $display("FAIL fill_busy_cnt_%0d got %b/%0d want 1/0", i, busy, wr_count); end
    end
    @(negedge clk);
    nvec++; if (RegWrite !== 1'b0) begin nerr++; $display("FAIL fill_end got %b want 0", RegWrite); end
    n0 = npulse;
    step(25);
    nvec++; if (npulse - n0 !== 0) begin nerr++; $display("FAIL fill_press_discarded got %0d pulses want 0", npulse - n0); end
    btn_wr = 1'b0;
    step(12);
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef FILL_PATTERN_EN
    test_fill();
    do_reset();
`endif
    test_clean_press();
    test_bounce();
    test_switch_change();
    test_wrap();
    test_reset_held();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
